serial_frame_tx: RTL and testbench
==================================

// Module: serial_frame_tx
// PURPOSE
//   Transmit end of the serial port-routing link: builds and shifts out one frame on serOut.
//   Frame = start bit, port number, payload length, then payload bits. This is the format the
//   receiving demux consumes to route payload bits to outputs p0..p3.
//   Sits between a parallel request source (host FSM / switches) and the serial line.
// PARAMETERS
//   PORT_W  2   port-number field width (selects 1 of 2**PORT_W destinations)
//   LEN_W   4   payload-length field width; max payload = 2**LEN_W-1 = 15 bits
//   DATA_W  15  payload register width; must equal 2**LEN_W-1
// PORTS
//   clk      in   1       system clock, rising edge
//   rst      in   1       asynchronous, active-low reset
//   clkEn    in   1       bit-rate enable; frame advances only on clk edges with clkEn=1
//   start    in   1       request to send; held high until ready falls
//   portIn   in   PORT_W  destination port, captured at accept
//   lenIn    in   LEN_W   payload bit count 0..15, captured at accept
//   dataIn   in   DATA_W  payload, captured at accept; bits above lenIn ignored
//   serOut   out  1       serial line, idle high
//   ready    out  1       1 in IDLE: a request can be accepted
//   busy     out  1       1 from accept until return to IDLE
//   done     out  1       1-clk pulse when the frame, stop bit included, completes
//   bitsLeft out  LEN_W   payload bits not yet driven (for 7-seg display)
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, serOut=1, ready=1, busy=0, done=0, bitsLeft=0, regs cleared.
//   All outputs registered. Every state change except done clearing needs clkEn=1.
//   "Period" = span between consecutive clkEn=1 edges; each bit lasts exactly 1 period.
//   Accept: edge with clkEn=1, state=IDLE, start=1 -> capture portIn/lenIn/dataIn,
//     go to START, serOut<=0, ready<=0, busy<=1, bitsLeft<=lenIn.
//   start with clkEn=0, or while busy: no effect. Inputs after accept: ignored.
//   States, one bit per period:
//     IDLE  serOut=1.
//     START one period, serOut=0 -> PORT.
//     PORT  PORT_W periods, port MSB first -> LEN.
//     LEN   LEN_W periods, length MSB first -> DATA if len>0, else STOP.
//     DATA  len periods, payload LSB first (dataIn[0] first); bitsLeft decrements
//           as each bit is driven; reaches 0 on the last bit -> STOP.
//     STOP  one period, serOut=1 (mandatory idle gap) -> IDLE.
//   done=1 for exactly one clk cycle, on the clk after the STOP->IDLE edge; ready=1 from that
//     edge. If clkEn is held 1 there, a held start is accepted at the next edge, so a stop bit
//     always separates frames.
//   Frame length = 1+PORT_W+LEN_W+len+1 periods (8..23 with defaults).
//   Field bit counters use separate width-safe counters; no wrap at len=15.
//   Reset mid-frame: serOut returns to 1 at once, frame abandoned, no done pulse.
// TESTING
//   clkEn=1, port=2, len=3, data=3'b101 -> serOut per period: 0,1,0,0,0,1,1,1,0,1,1;
//     done 1 clk after stop bit; bitsLeft 3,3..,2,1,0.
//   clkEn=1, port=3, len=0 -> serOut 0,1,1,0,0,0,0,1 (8 periods, no DATA), done pulses once.
//   port=0, len=15, data=15'h7FFF -> 0,0,0,1,1,1,1, fifteen 1s, stop 1; 23 periods total.
//   clkEn every 4th clk -> each bit held exactly 4 clks; done still 1 clk wide.
//   start held high through 2 frames -> second start bit follows exactly one stop period;
//     new dataIn applied mid-frame does not alter the current frame.
//   rst low during PORT bits -> serOut=1, busy=0 immediately; after release, accepts a fresh frame.

Source files
------------

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: shifts out start bit, port, payload length and payload,
// then a mandatory stop bit, advancing one bit per clkEn period.
module serial_frame_tx #(
    parameter int PORT_W = 2,
    parameter int LEN_W  = 4,
    parameter int DATA_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clkEn,
    input  logic              start,
    input  logic [PORT_W-1:0] portIn,
    input  logic [LEN_W-1:0]  lenIn,
    input  logic [DATA_W-1:0] dataIn,
    output logic              serOut,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  bitsLeft
);

    localparam int FW    = (PORT_W > LEN_W) ? PORT_W : LEN_W;
    localparam int CNT_W = $clog2(FW) + 1;

    typedef enum logic [2:0] {IDLE, START, PORT, LEN, DATA, STOP} state_t;

    state_t             state, stateNext;
    logic [PORT_W-1:0]  portSh, portShNext;
    logic [LEN_W-1:0]   lenSh, lenShNext;
    logic [DATA_W-1:0]  dataSh, dataShNext;
    logic [CNT_W-1:0]   cnt, cntNext;
    logic               serNext, readyNext, busyNext, doneNext;
    logic [LEN_W-1:0]   bitsLeftNext;

    // State and every output are registered; the next values come from the FSM below.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            portSh   <= '0;
            lenSh    <= '0;
            dataSh   <= '0;
            cnt      <= '0;
            serOut   <= 1'b1;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            bitsLeft <= '0;
        end else begin
            state    <= stateNext;
            portSh   <= portShNext;
            lenSh    <= lenShNext;
            dataSh   <= dataShNext;
            cnt      <= cntNext;
            serOut   <= serNext;
            ready    <= readyNext;
            busy     <= busyNext;
            done     <= doneNext;
            bitsLeft <= bitsLeftNext;
        end
    end

    // Each clkEn edge drives the next bit; done clears on any edge so it is one clk wide.
    always_comb begin
        stateNext    = state;
        portShNext   = portSh;
        lenShNext    = lenSh;
        dataShNext   = dataSh;
        cntNext      = cnt;
        serNext      = serOut;
        readyNext    = ready;
        busyNext     = busy;
        doneNext     = 1'b0;
        bitsLeftNext = bitsLeft;

        if (clkEn) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        stateNext    = START;
                        portShNext   = portIn;
                        lenShNext    = lenIn;
                        dataShNext   = dataIn;
                        cntNext      = '0;
                        serNext      = 1'b0;
                        readyNext    = 1'b0;
                        busyNext     = 1'b1;
                        bitsLeftNext = lenIn;
                    end
                end
                START: begin
                    stateNext  = PORT;
                    serNext    = portSh[PORT_W-1];
                    portShNext = portSh << 1;
                    cntNext    = '0;
                end
                PORT: begin
                    if (cnt == CNT_W'(PORT_W - 1)) begin
                        stateNext = LEN;
                        serNext   = lenSh[LEN_W-1];
                        lenShNext = lenSh << 1;
                        cntNext   = '0;
                    end else begin
                        serNext    = portSh[PORT_W-1];
                        portShNext = portSh << 1;
                        cntNext    = cnt + 1'b1;
                    end
                end
                LEN: begin
                    // bitsLeft still holds the captured length until DATA starts.
                    if (cnt == CNT_W'(LEN_W - 1)) begin
                        if (bitsLeft != '0) begin
                            stateNext    = DATA;
                            serNext      = dataSh[0];
                            dataShNext   = dataSh >> 1;
                            bitsLeftNext = bitsLeft - 1'b1;
                        end else begin
                            stateNext = STOP;
                            serNext   = 1'b1;
                        end
                    end else begin
                        serNext   = lenSh[LEN_W-1];
                        lenShNext = lenSh << 1;
                        cntNext   = cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bitsLeft == '0) begin
                        stateNext = STOP;
                        serNext   = 1'b1;
                    end else begin
                        serNext      = dataSh[0];
                        dataShNext   = dataSh >> 1;
                        bitsLeftNext = bitsLeft - 1'b1;
                    end
                end
                STOP: begin
                    stateNext = IDLE;
                    serNext   = 1'b1;
                    readyNext = 1'b1;
                    busyNext  = 1'b0;
                    doneNext  = 1'b1;
                end
                default: begin
                    stateNext = IDLE;
                    serNext   = 1'b1;
                    readyNext = 1'b1;
                    busyNext  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: stimulus queues expected line bits,
// a negedge monitor pops and compares them on each bit period.
module tb_serial_frame_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clkEn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  portIn = '0;
    logic [3:0]  lenIn = '0;
    logic [14:0] dataIn = '0;
    logic        serOut, ready, busy, done;
    logic [3:0]  bitsLeft;

    serial_frame_tx #(.PORT_W(2), .LEN_W(4), .DATA_W(15)) dut (
        .clk(clk), .rst(rst), .clkEn(clkEn), .start(start),
        .portIn(portIn), .lenIn(lenIn), .dataIn(dataIn),
        .serOut(serOut), .ready(ready), .busy(busy), .done(done),
        .bitsLeft(bitsLeft)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       bitv;
        logic [3:0] left;
        bit         last;
    } exp_t;

    exp_t expQ[$];
    exp_t cur;
    bit   haveCur = 0;
    int   checks = 0;
    int   errors = 0;
    int   donesExp = 0;
    int   donesSeen = 0;
    int   enDiv = 1;
    int   enCnt = 0;
    logic edgeEn = 1'b0;
    logic prevDone = 1'b0;

    // Bit-rate enable: one clk high out of every enDiv.
    always @(negedge clk) begin
        if (enCnt >= enDiv - 1) begin
            clkEn = 1'b1;
            enCnt = 0;
        end else begin
            clkEn = 1'b0;
            enCnt = enCnt + 1;
        end
    end

    always @(posedge clk) edgeEn <= clkEn;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: a new bit appears after every clkEn edge while busy, and must hold in between.
    always @(negedge clk) begin
        if (rst) begin
            if (busy === 1'b1) begin
                if (edgeEn) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        haveCur = 0;
                        $display("[TB] FAIL unexpected bit: got serOut=%0b expected none", serOut);
                    end else begin
                        cur = expQ.pop_front();
                        haveCur = 1;
                        checkOutput("serOut", 32'(serOut), 32'(cur.bitv));
                        checkOutput("bitsLeft", 32'(bitsLeft), 32'(cur.left));
                    end
                end else if (haveCur) begin
                    checkOutput("serOut hold", 32'(serOut), 32'(cur.bitv));
                end
            end
            if (done === 1'b1) begin
                donesSeen++;
                checkOutput("done width", 32'(prevDone), 32'd0);
                checkOutput("busy at done", 32'(busy), 32'd0);
                checkOutput("done after stop", 32'(haveCur && cur.last), 32'd1);
            end
            prevDone = done;
        end else begin
            prevDone = 1'b0;
        end
    end

    // Bits listed first-on-the-line in the MSB of 'bits'.
    task automatic pushFrame(input logic [22:0] bits, input int n, input int len);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.bitv = bits[n-1-i];
            if (i < 7)           e.left = 4'(len);
            else if (i < n - 1)  e.left = 4'(len - 1 - (i - 7));
            else                 e.left = 4'd0;
            e.last = (i == n - 1);
            expQ.push_back(e);
        end
        donesExp++;
    endtask

    task automatic waitAccept(input string name);
        int t = 0;
        while (ready !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        checkOutput(name, 32'(ready), 32'd0);
    endtask

    task automatic waitDones(input int target, input string name);
        int t = 0;
        while (donesSeen < target && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checkOutput(name, 32'(donesSeen), 32'(target));
    endtask

    task automatic applyStimulus(input logic [1:0] p, input logic [3:0] l, input logic [14:0] d,
                                 input logic [22:0] bits, input int n, input string name);
        pushFrame(bits, n, int'(l));
        @(negedge clk);
        portIn = p;
        lenIn  = l;
        dataIn = d;
        start  = 1'b1;
        waitAccept({name, " accept"});
        start  = 1'b0;
        dataIn = ~d;
        waitDones(donesExp, {name, " done"});
    endtask

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        checkOutput("reset serOut", 32'(serOut), 32'd1);
        checkOutput("reset ready", 32'(ready), 32'd1);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset bitsLeft", 32'(bitsLeft), 32'd0);
        rst = 1'b1;

        applyStimulus(2'd2, 4'd3, 15'h7FFD, 23'(11'b01000111011), 11, "port2 len3");
        applyStimulus(2'd3, 4'd0, 15'h7FFF, 23'(8'b01100001), 8, "port3 len0");
        applyStimulus(2'd0, 4'd15, 15'h7FFF, {3'b000, 20'hFFFFF}, 23, "port0 len15");

        enDiv = 4;
        applyStimulus(2'd1, 4'd2, 15'h0002, 23'(10'b0010010011), 10, "slow enable");
        enDiv = 1;
        repeat (4) @(negedge clk);

        // Back-to-back frames with start held; frame B's inputs appear mid-frame A.
        pushFrame(23'(9'b001000111), 9, 1);
        pushFrame(23'(10'b0100010101), 10, 2);
        @(negedge clk);
        portIn = 2'd1;
        lenIn  = 4'd1;
        dataIn = 15'h5555;
        start  = 1'b1;
        waitAccept("frameA accept");
        portIn = 2'd2;
        lenIn  = 4'd2;
        dataIn = 15'h0001;
        waitDones(donesExp - 1, "frameA done");
        waitAccept("frameB accept");
        start = 1'b0;
        waitDones(donesExp, "frameB done");

        // Reset during the port field.
        e.left = 4'd5;
        e.last = 0;
        e.bitv = 1'b0;
        expQ.push_back(e);
        expQ.push_back(e);
        @(negedge clk);
        portIn = 2'd1;
        lenIn  = 4'd5;
        dataIn = 15'h001F;
        start  = 1'b1;
        waitAccept("rst frame accept");
        start = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("mid-frame rst serOut", 32'(serOut), 32'd1);
        checkOutput("mid-frame rst busy", 32'(busy), 32'd0);
        checkOutput("mid-frame rst ready", 32'(ready), 32'd1);
        checkOutput("mid-frame rst queue", 32'(expQ.size()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        checkOutput("no done on rst", 32'(donesSeen), 32'(donesExp));
        applyStimulus(2'd3, 4'd0, 15'h0000, 23'(8'b01100001), 8, "after rst");

        repeat (4) @(negedge clk);
        checkOutput("final queue", 32'(expQ.size()), 32'd0);
        checkOutput("done count", 32'(donesSeen), 32'(donesExp));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
